// File: rtl/io_out_arb_if.sv
// Shared bundle between the per-core out_en pins and the arbitrated output channel.
// With IO_ARB_TAG_EN defined, the bundle also carries m_tag, the index of the core
// that produced the current m_data word.
interface io_out_arb_if #(
   parameter int NUBITS = 32,
   parameter int NCORES = 4
);
   localparam int TW = (NCORES > 1) ? $clog2(NCORES) : 1;

   logic [NCORES*NUBITS-1:0] s_data;
   logic [NCORES-1:0]        s_en;
   logic [NCORES-1:0]        s_full;
   logic [NCORES-1:0]        ovf;
   logic [NCORES-1:0]        ovf_clr;
   logic [NUBITS-1:0]        m_data;
   logic                     m_valid;
   logic                     m_ready;
`ifdef IO_ARB_TAG_EN
   logic [TW-1:0]            m_tag;

   modport slave  (input  s_data, s_en, ovf_clr, m_ready,
                   output s_full, ovf, m_data, m_valid, m_tag);
   modport master (output s_data, s_en, ovf_clr, m_ready,
                   input  s_full, ovf, m_data, m_valid, m_tag);
`else
   modport slave  (input  s_data, s_en, ovf_clr, m_ready,
                   output s_full, ovf, m_data, m_valid);
   modport master (output s_data, s_en, ovf_clr, m_ready,
                   input  s_full, ovf, m_data, m_valid);
`endif
endinterface

// File: rtl/io_out_arb.sv
// io_out_arb: per-core write FIFOs drained round-robin into one registered
// valid/ready output stage. Cores cannot be stalled, so a push into a full FIFO
// that is not popped at the same edge is dropped and flagged in sticky ovf.
// Optional feature macro IO_ARB_TAG_EN adds m_tag (granted core index).
module io_out_arb #(
   parameter int NUBITS = 32,
   parameter int NCORES = 4,
   parameter int FDEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   io_out_arb_if.slave     bus
);
   localparam int AW = $clog2(FDEPTH);
   localparam int CW = AW + 1;
   localparam int RW = (NCORES > 1) ? $clog2(NCORES) : 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FDEPTH);

   logic [NUBITS-1:0] mem_q    [NCORES][FDEPTH];
   logic [AW-1:0]     wr_ptr_q [NCORES];
   logic [AW-1:0]     wr_ptr_d [NCORES];
   logic [AW-1:0]     rd_ptr_q [NCORES];
   logic [AW-1:0]     rd_ptr_d [NCORES];
   logic [CW-1:0]     cnt_q    [NCORES];
   logic [CW-1:0]     cnt_d    [NCORES];

   logic [NCORES-1:0] full_q, full_d;
   logic [NCORES-1:0] ovf_q, ovf_d;
   logic [NCORES-1:0] push_ok, pop;

   logic [NUBITS-1:0] m_data_q, m_data_d;
   logic              m_valid_q, m_valid_d;
   logic [RW-1:0]     rr_q, rr_d;
   logic              ld, found;
   logic [RW-1:0]     gnt;
`ifdef IO_ARB_TAG_EN
   logic [RW-1:0]     tag_q, tag_d;
`endif

   // (base + off) mod NCORES, valid for any NCORES, not only powers of two
   function automatic logic [RW-1:0] wrap_add(input logic [RW-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= NCORES) s = s - NCORES;
      return RW'(s);
   endfunction

   // round-robin search from rr over registered counts (no same-cycle bypass)
   always_comb begin
      found = 1'b0;
      gnt   = '0;
      for (int off = 0; off < NCORES; off++) begin
         if (!found && cnt_q[wrap_add(rr_q, off)] != '0) begin
            found = 1'b1;
            gnt   = wrap_add(rr_q, off);
         end
      end
   end

   // next-state for FIFOs, flags and the output register
   always_comb begin
      ld = !m_valid_q || bus.m_ready;
      for (int i = 0; i < NCORES; i++) begin
         pop[i]     = ld && found && (gnt == RW'(i));
         // a full FIFO still accepts a word when its head leaves at the same edge
         push_ok[i] = bus.s_en[i] && ((cnt_q[i] != DEPTH_C) || pop[i]);
         wr_ptr_d[i] = push_ok[i] ? wr_ptr_q[i] + AW'(1) : wr_ptr_q[i];
         rd_ptr_d[i] = pop[i]     ? rd_ptr_q[i] + AW'(1) : rd_ptr_q[i];
         case ({push_ok[i], pop[i]})
            2'b10:   cnt_d[i] = cnt_q[i] + CW'(1);
            2'b01:   cnt_d[i] = cnt_q[i] - CW'(1);
            default: cnt_d[i] = cnt_q[i];
         endcase
         full_d[i] = (cnt_d[i] == DEPTH_C);
         // a drop at the same edge as a clear keeps the flag set
         ovf_d[i]  = (bus.s_en[i] && !push_ok[i]) || (ovf_q[i] && !bus.ovf_clr[i]);
      end

      m_valid_d = m_valid_q;
      m_data_d  = m_data_q;
      rr_d      = rr_q;
`ifdef IO_ARB_TAG_EN
      tag_d     = tag_q;
`endif
      if (ld) begin
         m_valid_d = found;
         if (found) begin
            m_data_d = mem_q[gnt][rd_ptr_q[gnt]];
            rr_d     = wrap_add(gnt, 1);
`ifdef IO_ARB_TAG_EN
            tag_d    = gnt;
`endif
         end
      end
   end

   // FIFO storage; validity is tracked by the reset pointers/counts only
   always_ff @(posedge clk) begin
      for (int i = 0; i < NCORES; i++) begin
         if (push_ok[i]) mem_q[i][wr_ptr_q[i]] <= bus.s_data[i*NUBITS +: NUBITS];
      end
   end

   // control and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NCORES; i++) begin
            wr_ptr_q[i] <= '0;
            rd_ptr_q[i] <= '0;
            cnt_q[i]    <= '0;
         end
         full_q    <= '0;
         ovf_q     <= '0;
         m_data_q  <= '0;
         m_valid_q <= 1'b0;
         rr_q      <= '0;
`ifdef IO_ARB_TAG_EN
         tag_q     <= '0;
`endif
      end else begin
         for (int i = 0; i < NCORES; i++) begin
            wr_ptr_q[i] <= wr_ptr_d[i];
            rd_ptr_q[i] <= rd_ptr_d[i];
            cnt_q[i]    <= cnt_d[i];
         end
         full_q    <= full_d;
         ovf_q     <= ovf_d;
         m_data_q  <= m_data_d;
         m_valid_q <= m_valid_d;
         rr_q      <= rr_d;
`ifdef IO_ARB_TAG_EN
         tag_q     <= tag_d;
`endif
      end
   end

   assign bus.s_full  = full_q;
   assign bus.ovf     = ovf_q;
   assign bus.m_data  = m_data_q;
   assign bus.m_valid = m_valid_q;
`ifdef IO_ARB_TAG_EN
   assign bus.m_tag   = tag_q;
`endif

endmodule

// File: tb/tb_io_out_arb.sv
// Directed bench for io_out_arb with NUBITS=32, NCORES=4, FDEPTH=4.
// Each table row: inputs applied after one edge, outputs compared 1 ns after the next.
module tb_io_out_arb;
   localparam int NUBITS = 32;
   localparam int NCORES = 4;
   localparam int FDEPTH = 4;

   logic clk;
   logic rst;

   io_out_arb_if #(.NUBITS(NUBITS), .NCORES(NCORES)) bus ();

   io_out_arb #(.NUBITS(NUBITS), .NCORES(NCORES), .FDEPTH(FDEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic         rst;
      logic [3:0]   en;
      logic [127:0] data;
      logic         rdy;
      logic [3:0]   clr;
      logic         ev;
      logic [31:0]  ed;
      logic [3:0]   ef;
      logic [3:0]   eo;
      logic [1:0]   et;
   } vec_t;

   vec_t tbl[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic vec(input logic r, input logic [3:0] en,
                      input int d0, input int d1, input int d2, input int d3,
                      input logic rdy, input logic [3:0] clr,
                      input logic ev, input int ed, input logic [3:0] ef,
                      input logic [3:0] eo, input int et);
      vec_t v;
      v.rst  = r;
      v.en   = en;
      v.data = {32'(d3), 32'(d2), 32'(d1), 32'(d0)};
      v.rdy  = rdy;
      v.clr  = clr;
      v.ev   = ev;
      v.ed   = 32'(ed);
      v.ef   = ef;
      v.eo   = eo;
      v.et   = 2'(et);
      tbl.push_back(v);
   endtask

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s step %0d: got %0h, expected %0h", nm, idx, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input int idx, input logic ev, input logic [31:0] ed,
                          input logic [3:0] ef, input logic [3:0] eo, input logic [1:0] et);
      chk({tag, " m_valid"}, idx, 32'(bus.m_valid), 32'(ev));
      chk({tag, " m_data"},  idx, bus.m_data, ed);
      chk({tag, " s_full"},  idx, 32'(bus.s_full), 32'(ef));
      chk({tag, " ovf"},     idx, 32'(bus.ovf), 32'(eo));
`ifdef IO_ARB_TAG_EN
      chk({tag, " m_tag"},   idx, 32'(bus.m_tag), 32'(et));
`else
      if (et > 2'd3) $display("unreachable tag %0d", et);
`endif
   endtask

   task automatic idle_in();
      bus.s_en    = '0;
      bus.s_data  = '0;
      bus.ovf_clr = '0;
   endtask

   initial begin
      rst = 1'b1;
      idle_in();
      bus.m_ready = 1'b0;

      // single word from core 2: visible after the second edge, for one cycle
      vec(0, 4'b0100, 0, 0, 7, 0,    1, 4'b0000, 0, 0,  4'b0000, 4'b0000, 0);
      vec(0, 4'b0000, 0, 0, 0, 0,    1, 4'b0000, 1, 7,  4'b0000, 4'b0000, 2);
      vec(0, 4'b0000, 0, 0, 0, 0,    1, 4'b0000, 0, 7,  4'b0000, 4'b0000, 2);
      // fairness from rr=0
      vec(1, 4'b0000, 0, 0, 0, 0,    1, 4'b0000, 0, 0,  4'b0000, 4'b0000, 0);
      vec(0, 4'b1111, 10, 11, 12, 13, 1, 4'b0000, 0, 0,  4'b0000, 4'b0000, 0);
      vec(0, 4'b0000, 0, 0, 0, 0,    1, 4'b0000, 1, 10, 4'b0000, 4'b0000, 0);
      vec(0, 4'b0000, 0, 0, 0, 0,    1, 4'b0000, 1, 11, 4'b0000, 4'b0000, 1);
      vec(0, 4'b0000, 0, 0, 0, 0,    1, 4'b0000, 1, 12, 4'b0000, 4'b0000, 2);
      vec(0, 4'b0000, 0, 0, 0, 0,    1, 4'b0000, 1, 13, 4'b0000, 4'b0000, 3);
      vec(0, 4'b1001, 20, 0, 0, 23,  1, 4'b0000, 0, 13, 4'b0000, 4'b0000, 3);
      vec(0, 4'b0000, 0, 0, 0, 0,    1, 4'b0000, 1, 20, 4'b0000, 4'b0000, 0);
      vec(0, 4'b0000, 0, 0, 0, 0,    1, 4'b0000, 1, 23, 4'b0000, 4'b0000, 3);
      vec(0, 4'b0000, 0, 0, 0, 0,    1, 4'b0000, 0, 23, 4'b0000, 4'b0000, 3);
      // backpressure on core 1: word 1 sits in the output register, 2..5 fill the FIFO, 6 drops
      vec(0, 4'b0010, 0, 1, 0, 0,    0, 4'b0000, 0, 23, 4'b0000, 4'b0000, 3);
      vec(0, 4'b0010, 0, 2, 0, 0,    0, 4'b0000, 1, 1,  4'b0000, 4'b0000, 1);
      vec(0, 4'b0010, 0, 3, 0, 0,    0, 4'b0000, 1, 1,  4'b0000, 4'b0000, 1);
      vec(0, 4'b0010, 0, 4, 0, 0,    0, 4'b0000, 1, 1,  4'b0000, 4'b0000, 1);
      vec(0, 4'b0010, 0, 5, 0, 0,    0, 4'b0000, 1, 1,  4'b0010, 4'b0000, 1);
      vec(0, 4'b0010, 0, 6, 0, 0,    0, 4'b0000, 1, 1,  4'b0010, 4'b0010, 1);
      vec(0, 4'b0000, 0, 0, 0, 0,    1, 4'b0000, 1, 2,  4'b0000, 4'b0010, 1);
      vec(0, 4'b0000, 0, 0, 0, 0,    1, 4'b0000, 1, 3,  4'b0000, 4'b0010, 1);
      vec(0, 4'b0000, 0, 0, 0, 0,    1, 4'b0000, 1, 4,  4'b0000, 4'b0010, 1);
      vec(0, 4'b0000, 0, 0, 0, 0,    1, 4'b0000, 1, 5,  4'b0000, 4'b0010, 1);
      vec(0, 4'b0000, 0, 0, 0, 0,    1, 4'b0000, 0, 5,  4'b0000, 4'b0010, 1);
      vec(0, 4'b0000, 0, 0, 0, 0,    1, 4'b0010, 0, 5,  4'b0000, 4'b0000, 1);
      // set beats clear on core 3, then clear alone
      vec(0, 4'b1000, 0, 0, 0, 30,   0, 4'b0000, 0, 5,  4'b0000, 4'b0000, 1);
      vec(0, 4'b1000, 0, 0, 0, 31,   0, 4'b0000, 1, 30, 4'b0000, 4'b0000, 3);
      vec(0, 4'b1000, 0, 0, 0, 32,   0, 4'b0000, 1, 30, 4'b0000, 4'b0000, 3);
      vec(0, 4'b1000, 0, 0, 0, 33,   0, 4'b0000, 1, 30, 4'b0000, 4'b0000, 3);
      vec(0, 4'b1000, 0, 0, 0, 34,   0, 4'b0000, 1, 30, 4'b1000, 4'b0000, 3);
      vec(0, 4'b1000, 0, 0, 0, 35,   0, 4'b1000, 1, 30, 4'b1000, 4'b1000, 3);
      vec(0, 4'b0000, 0, 0, 0, 0,    0, 4'b1000, 1, 30, 4'b1000, 4'b0000, 3);
      vec(0, 4'b0000, 0, 0, 0, 0,    1, 4'b0000, 1, 31, 4'b0000, 4'b0000, 3);
      vec(0, 4'b0000, 0, 0, 0, 0,    1, 4'b0000, 1, 32, 4'b0000, 4'b0000, 3);
      vec(0, 4'b0000, 0, 0, 0, 0,    1, 4'b0000, 1, 33, 4'b0000, 4'b0000, 3);
      vec(0, 4'b0000, 0, 0, 0, 0,    1, 4'b0000, 1, 34, 4'b0000, 4'b0000, 3);
      vec(0, 4'b0000, 0, 0, 0, 0,    1, 4'b0000, 0, 34, 4'b0000, 4'b0000, 3);
      // core 0 full, then push and pop at every edge: no drop, one word per cycle
      vec(0, 4'b0001, 40, 0, 0, 0,   0, 4'b0000, 0, 34, 4'b0000, 4'b0000, 3);
      vec(0, 4'b0001, 41, 0, 0, 0,   0, 4'b0000, 1, 40, 4'b0000, 4'b0000, 0);
      vec(0, 4'b0001, 42, 0, 0, 0,   0, 4'b0000, 1, 40, 4'b0000, 4'b0000, 0);
      vec(0, 4'b0001, 43, 0, 0, 0,   0, 4'b0000, 1, 40, 4'b0000, 4'b0000, 0);
      vec(0, 4'b0001, 44, 0, 0, 0,   0, 4'b0000, 1, 40, 4'b0001, 4'b0000, 0);
      vec(0, 4'b0001, 45, 0, 0, 0,   1, 4'b0000, 1, 41, 4'b0001, 4'b0000, 0);
      vec(0, 4'b0001, 46, 0, 0, 0,   1, 4'b0000, 1, 42, 4'b0001, 4'b0000, 0);
      vec(0, 4'b0001, 47, 0, 0, 0,   1, 4'b0000, 1, 43, 4'b0001, 4'b0000, 0);
      vec(0, 4'b0001, 48, 0, 0, 0,   1, 4'b0000, 1, 44, 4'b0001, 4'b0000, 0);
      vec(0, 4'b0000, 0, 0, 0, 0,    1, 4'b0000, 1, 45, 4'b0000, 4'b0000, 0);
      vec(0, 4'b0000, 0, 0, 0, 0,    1, 4'b0000, 1, 46, 4'b0000, 4'b0000, 0);
      vec(0, 4'b0000, 0, 0, 0, 0,    1, 4'b0000, 1, 47, 4'b0000, 4'b0000, 0);
      vec(0, 4'b0000, 0, 0, 0, 0,    1, 4'b0000, 1, 48, 4'b0000, 4'b0000, 0);
      vec(0, 4'b0000, 0, 0, 0, 0,    1, 4'b0000, 0, 48, 4'b0000, 4'b0000, 0);
      // load up state ahead of the asynchronous reset
      vec(0, 4'b0100, 0, 0, 50, 0,   0, 4'b0000, 0, 48, 4'b0000, 4'b0000, 0);
      vec(0, 4'b0100, 0, 0, 51, 0,   0, 4'b0000, 1, 50, 4'b0000, 4'b0000, 2);
      vec(0, 4'b0001, 60, 0, 0, 0,   0, 4'b0000, 1, 50, 4'b0000, 4'b0000, 2);
      vec(0, 4'b0001, 61, 0, 0, 0,   0, 4'b0000, 1, 50, 4'b0000, 4'b0000, 2);
      vec(0, 4'b0001, 62, 0, 0, 0,   0, 4'b0000, 1, 50, 4'b0000, 4'b0000, 2);
      vec(0, 4'b0001, 63, 0, 0, 0,   0, 4'b0000, 1, 50, 4'b0001, 4'b0000, 2);
      vec(0, 4'b0001, 64, 0, 0, 0,   0, 4'b0000, 1, 50, 4'b0001, 4'b0001, 2);

      repeat (2) @(posedge clk);
      #1;
      chk_all("reset", -1, 1'b0, 32'd0, 4'b0000, 4'b0000, 2'd0);
      rst = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         rst         = tbl[i].rst;
         bus.s_en    = tbl[i].en;
         bus.s_data  = tbl[i].data;
         bus.m_ready = tbl[i].rdy;
         bus.ovf_clr = tbl[i].clr;
         @(posedge clk);
         #1;
         chk_all("vec", i, tbl[i].ev, tbl[i].ed, tbl[i].ef, tbl[i].eo, tbl[i].et);
      end

      // asynchronous reset between edges while output valid, FIFOs full and ovf set
      rst = 1'b0;
      idle_in();
      bus.m_ready = 1'b0;
      #3;
      rst = 1'b1;
      #1;
      chk_all("async_rst", 100, 1'b0, 32'd0, 4'b0000, 4'b0000, 2'd0);
      #1;
      rst = 1'b0;
      bus.m_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk);
         #1;
         chk_all("no_stale", 101 + c, 1'b0, 32'd0, 4'b0000, 4'b0000, 2'd0);
      end
      bus.s_en   = 4'b0010;
      bus.s_data = {32'd0, 32'd0, 32'd77, 32'd0};
      @(posedge clk);
      #1;
      idle_in();
      chk_all("post_rst_push", 105, 1'b0, 32'd0, 4'b0000, 4'b0000, 2'd0);
      @(posedge clk);
      #1;
      chk_all("post_rst_out", 106, 1'b1, 32'd77, 4'b0000, 4'b0000, 2'd1);
      @(posedge clk);
      #1;
      chk_all("post_rst_done", 107, 1'b0, 32'd77, 4'b0000, 4'b0000, 2'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
